// File: rtl/score_bcd_counter.sv
// ============================================================================
// score_bcd_counter : vsync-paced 3-digit BCD score and high score, bus controlled
// Revision 1.0
// ============================================================================
`default_nettype none

module score_bcd_counter #(
   parameter logic [7:0] RATE_DEFAULT = 8'd6,
   parameter logic       SATURATE     = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic [2:0]  address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        vsync_n,
   output logic [3:0]  score_d2,
   output logic [3:0]  score_d1,
   output logic [3:0]  score_d0,
   output logic [3:0]  hi_d2,
   output logic [3:0]  hi_d1,
   output logic [3:0]  hi_d0,
   output logic        frame_tick,
   output logic        wrap_flag
);

   localparam logic [2:0] ADDR_CTRL  = 3'd0;
   localparam logic [2:0] ADDR_RATE  = 3'd1;
   localparam logic [2:0] ADDR_HICLR = 3'd2;
   localparam logic [2:0] ADDR_STAT  = 3'd3;

   logic       run;
   logic [7:0] rate;
   logic [7:0] frame_cnt;
   logic       vs_q;

   logic       wr_en, ctrl_wr, rate_wr, hi_clr, clear, clr_wrap;
   logic       tick, advance, at_max, wrap_now, score_gt_hi;
   logic [7:0] rate_lim;
   logic [3:0] nxt_d2, nxt_d1, nxt_d0;
   logic       unused_wdata;

   assign wr_en    = chipselect & write;
   assign ctrl_wr  = wr_en && (address == ADDR_CTRL);
   assign rate_wr  = wr_en && (address == ADDR_RATE);
   assign hi_clr   = wr_en && (address == ADDR_HICLR);
   assign clear    = ctrl_wr & writedata[1];
   assign clr_wrap = ctrl_wr & writedata[2];
   assign unused_wdata = ^writedata[31:8];

   assign tick     = vs_q & ~vsync_n;
   // A stored rate of 0 behaves as 1 frame per point.
   assign rate_lim = (rate == 8'd0) ? 8'd0 : rate - 8'd1;
   assign advance  = tick & run & (frame_cnt >= rate_lim);
   assign at_max   = (score_d2 == 4'd9) && (score_d1 == 4'd9) && (score_d0 == 4'd9);
   assign wrap_now = advance & ~clear & at_max & ~SATURATE;
   // Packed BCD compares numerically when read MSD first.
   assign score_gt_hi = {score_d2, score_d1, score_d0} > {hi_d2, hi_d1, hi_d0};

   always_comb begin
      nxt_d2 = score_d2;
      nxt_d1 = score_d1;
      nxt_d0 = score_d0;
      if (at_max) begin
         if (!SATURATE) begin
            nxt_d2 = 4'd0;
            nxt_d1 = 4'd0;
            nxt_d0 = 4'd0;
         end
      end else if (score_d0 == 4'd9) begin
         nxt_d0 = 4'd0;
         if (score_d1 == 4'd9) begin
            nxt_d1 = 4'd0;
            nxt_d2 = score_d2 + 4'd1;
         end else begin
            nxt_d1 = score_d1 + 4'd1;
         end
      end else begin
         nxt_d0 = score_d0 + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run  <= 1'b0;
         rate <= RATE_DEFAULT;
      end else begin
         if (ctrl_wr) run  <= writedata[0];
         if (rate_wr) rate <= writedata[7:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_q       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         vs_q       <= vsync_n;
         frame_tick <= tick;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= 8'd0;
         score_d2  <= 4'd0;
         score_d1  <= 4'd0;
         score_d0  <= 4'd0;
      end else if (clear) begin
         frame_cnt <= 8'd0;
         score_d2  <= 4'd0;
         score_d1  <= 4'd0;
         score_d0  <= 4'd0;
      end else if (tick && run) begin
         if (advance) begin
            frame_cnt <= 8'd0;
            score_d2  <= nxt_d2;
            score_d1  <= nxt_d1;
            score_d0  <= nxt_d0;
         end else begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // Uses the pre-clear score, so a clear never loses a pending high-score update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_d2 <= 4'd0;
         hi_d1 <= 4'd0;
         hi_d0 <= 4'd0;
      end else if (hi_clr) begin
         hi_d2 <= 4'd0;
         hi_d1 <= 4'd0;
         hi_d0 <= 4'd0;
      end else if (score_gt_hi) begin
         hi_d2 <= score_d2;
         hi_d1 <= score_d1;
         hi_d0 <= score_d0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         wrap_flag <= 1'b0;
      else if (wrap_now) wrap_flag <= 1'b1;
      else if (clr_wrap) wrap_flag <= 1'b0;
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         ADDR_CTRL: readdata = {31'd0, run};
         ADDR_RATE: readdata = {24'd0, rate};
         ADDR_STAT: readdata = {8'd0, hi_d2, hi_d1, hi_d0, score_d2, score_d1, score_d0};
         default:   readdata = 32'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: register vector table plus vsync-driven score sequences.
`default_nettype none

module tb_score_bcd_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect, write;
   logic [2:0]  address;
   logic [31:0] writedata;
   logic        vsync_n;
   logic [31:0] readdata, readdata_w;
   logic [3:0]  score_d2, score_d1, score_d0, hi_d2, hi_d1, hi_d0;
   logic [3:0]  w_s2, w_s1, w_s0, w_h2, w_h1, w_h0;
   logic        frame_tick, wrap_flag, w_frame_tick, w_wrap_flag;

   int checks = 0;
   int errors = 0;
   int ft_count = 0;

   always #5 clk = ~clk;

   score_bcd_counter dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
      .address(address), .writedata(writedata), .readdata(readdata), .vsync_n(vsync_n),
      .score_d2(score_d2), .score_d1(score_d1), .score_d0(score_d0),
      .hi_d2(hi_d2), .hi_d1(hi_d1), .hi_d0(hi_d0),
      .frame_tick(frame_tick), .wrap_flag(wrap_flag)
   );

   score_bcd_counter #(.SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
      .address(address), .writedata(writedata), .readdata(readdata_w), .vsync_n(vsync_n),
      .score_d2(w_s2), .score_d1(w_s1), .score_d0(w_s0),
      .hi_d2(w_h2), .hi_d1(w_h1), .hi_d0(w_h0),
      .frame_tick(w_frame_tick), .wrap_flag(w_wrap_flag)
   );

   always @(posedge clk) if (frame_tick) ft_count <= ft_count + 1;

   typedef struct { string name; logic [31:0] val; } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic        wr;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      string       name;
   } vec_t;
   vec_t vecs[8];

   function automatic logic [31:0] sc();
      return {20'd0, score_d2, score_d1, score_d0};
   endfunction

   function automatic logic [31:0] hs();
      return {20'd0, hi_d2, hi_d1, hi_d0};
   endfunction

   task automatic push(input string n, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.val  = v;
      sbq.push_back(e);
   endtask

   task automatic pop(input logic [31:0] got);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty got %h", got);
      end else begin
         e = sbq.pop_front();
         if (got !== e.val) begin
            errors++;
            $display("FAIL %s got %h expected %h", e.name, got, e.val);
         end
      end
   endtask

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] expv);
      push(n, expv);
      pop(got);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      step();
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic pulse();
      vsync_n = 1'b0;
      step();
      vsync_n = 1'b1;
      step();
   endtask

   task automatic read_reg(input string n, input logic [2:0] a, input logic [31:0] expv);
      push(n, expv);
      address = a;
      #1;
      pop(readdata);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int ft0;
      vecs[0] = '{1'b1, 3'd1, 32'h0000_0102, 32'd2,  "rate_write"};
      vecs[1] = '{1'b1, 3'd0, 32'h0000_0001, 32'd1,  "ctrl_run"};
      vecs[2] = '{1'b0, 3'd2, 32'd0,         32'd0,  "hiclr_reads_zero"};
      vecs[3] = '{1'b1, 3'd5, 32'h0000_00FF, 32'd0,  "addr5_ignored"};
      vecs[4] = '{1'b0, 3'd4, 32'd0,         32'd0,  "addr4_zero"};
      vecs[5] = '{1'b0, 3'd3, 32'd0,         32'd0,  "stat_zero"};
      vecs[6] = '{1'b1, 3'd7, 32'h0000_0003, 32'd0,  "addr7_ignored"};
      vecs[7] = '{1'b0, 3'd1, 32'd0,         32'd2,  "rate_kept"};

      reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = 3'd0;
      writedata = 32'd0; vsync_n = 1'b1;
      step(); step();
      chk("rst_score", sc(), 32'd0);
      chk("rst_hi", hs(), 32'd0);
      chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
      chk("rst_wrap", {31'd0, wrap_flag}, 32'd0);
      read_reg("rst_rate", 3'd1, 32'd6);
      read_reg("rst_run", 3'd0, 32'd0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         push(vecs[i].name, vecs[i].exp_rd);
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
         address = vecs[i].addr;
         #1;
         pop(readdata);
      end

      // Rate 2, six frames -> three points.
      ft0 = ft_count;
      repeat (6) pulse();
      chk("t1_score", sc(), 32'h003);
      chk("t1_frame_ticks", ft_count - ft0, 32'd6);
      read_reg("t1_stat", 3'd3, 32'h0000_3003);

      // Carry chains in one clock.
      bus_write(3'd1, 32'd1);
      repeat (6) pulse();
      chk("t3_score_009", sc(), 32'h009);
      vsync_n = 1'b0;
      step();
      chk("t3_score_010", sc(), 32'h010);
      chk("t3_hi_lags", hs(), 32'h009);
      vsync_n = 1'b1;
      step();
      chk("t3_hi_010", hs(), 32'h010);
      repeat (89) pulse();
      chk("t3_score_099", sc(), 32'h099);
      vsync_n = 1'b0;
      step();
      chk("t3_score_100", sc(), 32'h100);
      vsync_n = 1'b1;
      step();

      // High score latency, clear in a tick cycle, clear capturing a pending hi.
      bus_write(3'd0, 32'd3);
      chk("t4_clear", sc(), 32'h000);
      bus_write(3'd2, 32'd0);
      chk("t4_hiclr", hs(), 32'h000);
      repeat (41) pulse();
      vsync_n = 1'b0;
      step();
      chk("t4_score_042", sc(), 32'h042);
      chk("t4_hi_041", hs(), 32'h041);
      vsync_n = 1'b1;
      step();
      chk("t4_hi_042", hs(), 32'h042);
      vsync_n = 1'b0;
      chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 32'd3;
      step();
      chipselect = 1'b0; write = 1'b0;
      chk("t4_clear_beats_tick", sc(), 32'h000);
      vsync_n = 1'b1;
      step();
      chk("t4_hi_kept", hs(), 32'h042);
      repeat (42) pulse();
      vsync_n = 1'b0;
      step();
      chk("t4_score_043", sc(), 32'h043);
      vsync_n = 1'b1;
      bus_write(3'd0, 32'd3);
      chk("t4_clear_score", sc(), 32'h000);
      chk("t4_hi_captured", hs(), 32'h043);

      // Stopped counter holds score and frame count; HICLR.
      bus_write(3'd1, 32'd2);
      repeat (3) pulse();
      chk("t5_score_001", sc(), 32'h001);
      bus_write(3'd0, 32'd0);
      repeat (10) pulse();
      chk("t5_stopped", sc(), 32'h001);
      read_reg("t5_run_off", 3'd0, 32'd0);
      bus_write(3'd0, 32'd1);
      pulse();
      chk("t5_cnt_held", sc(), 32'h002);
      bus_write(3'd2, 32'd0);
      chk("t5_hiclr", hs(), 32'h000);
      read_reg("t5_stat", 3'd3, 32'h0000_0002);
      step();
      chk("t5_hi_recapture", hs(), 32'h002);

      // Asynchronous reset mid-count.
      bus_write(3'd1, 32'd1);
      repeat (120) pulse();
      vsync_n = 1'b0;
      step();
      chk("t6_score_123", sc(), 32'h123);
      chk("t6_tick_high", {31'd0, frame_tick}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_score", sc(), 32'h000);
      chk("t6_async_hi", hs(), 32'h000);
      chk("t6_async_tick", {31'd0, frame_tick}, 32'd0);
      read_reg("t6_rate_default", 3'd1, 32'd6);
      vsync_n = 1'b1;
      step(); step();
      reset = 1'b0;
      step();

      // Saturation versus wrap, rate 0 treated as 1.
      bus_write(3'd1, 32'd0);
      read_reg("t2_rate_zero", 3'd1, 32'd0);
      bus_write(3'd0, 32'd1);
      repeat (999) pulse();
      chk("t2_score_999", sc(), 32'h999);
      chk("t2_wrap_score_999", {20'd0, w_s2, w_s1, w_s0}, 32'h999);
      chk("t2_wrap_flag_pre", {31'd0, w_wrap_flag}, 32'd0);
      pulse();
      chk("t2_saturated", sc(), 32'h999);
      chk("t2_sat_no_flag", {31'd0, wrap_flag}, 32'd0);
      chk("t2_wrapped", {20'd0, w_s2, w_s1, w_s0}, 32'h000);
      chk("t2_wrap_flag", {31'd0, w_wrap_flag}, 32'd1);
      chk("t2_wrap_hi", {20'd0, w_h2, w_h1, w_h0}, 32'h999);
      bus_write(3'd0, 32'd5);
      chk("t2_clr_wrap", {31'd0, w_wrap_flag}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
